// File: rtl/sec_ded_encoder_pipe_pkg.sv
// Shared definitions for the (72,64) SEC-DED code: codeword types, the
// parity-check matrix split into data and parity columns, the inverse of the
// parity submatrix, and elaboration-time sanity checks on the code.
package sec_ded_encoder_pipe_pkg;

    localparam int MSG_BITS = 64;
    localparam int PAR_BITS = 8;
    localparam int CW_BITS  = MSG_BITS + PAR_BITS;

    typedef logic [CW_BITS-1:0]  codeword_t;
    typedef logic [MSG_BITS-1:0] msg_t;
    typedef logic [PAR_BITS-1:0] parity_t;

    // Row r of H_DATA holds bit r of every data column; same layout for H_PAR.
    typedef logic [PAR_BITS-1:0][MSG_BITS-1:0] h_data_t;
    typedef logic [PAR_BITS-1:0][PAR_BITS-1:0] h_par_t;

    function automatic int popcount8(input logic [7:0] v);
        int n;
        n = 0;
        for (int b = 0; b < 8; b++) begin
            n += int'(v[b]);
        end
        return n;
    endfunction

    // Data columns are the first 64 byte values, in ascending numeric order,
    // whose weight is 3 or 5. Odd weight keeps every column distinct from
    // the XOR of any two columns, which is what gives double-error detection.
    function automatic h_data_t build_h_data();
        h_data_t     h;
        int          n;
        logic [7:0]  v;
        h = '0;
        n = 0;
        for (int c = 1; c < 256; c++) begin
            v = c[7:0];
            if ((popcount8(v) == 3 || popcount8(v) == 5) && n < MSG_BITS) begin
                for (int r = 0; r < PAR_BITS; r++) begin
                    h[r][n] = v[r];
                end
                n++;
            end
        end
        return h;
    endfunction

    function automatic h_par_t build_ident();
        h_par_t h;
        h = '0;
        for (int r = 0; r < PAR_BITS; r++) begin
            h[r][r] = 1'b1;
        end
        return h;
    endfunction

    // Parity columns are the unit vectors, so parity bit k is the only parity
    // bit seen by syndrome bit k. The inverse is kept explicit so the parity
    // generator stays correct if the parity submatrix is ever reshuffled.
    localparam h_data_t H_DATA = build_h_data();
    localparam h_par_t  H_PAR  = build_ident();
    localparam h_par_t  P_INV  = build_ident();

    // H_PAR * P_INV must be the identity over GF(2).
    function automatic bit p_inv_ok();
        logic acc;
        for (int i = 0; i < PAR_BITS; i++) begin
            for (int j = 0; j < PAR_BITS; j++) begin
                acc = 1'b0;
                for (int k = 0; k < PAR_BITS; k++) begin
                    acc ^= H_PAR[i][k] & P_INV[k][j];
                end
                if (acc != (i == j)) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    // Every one of the 72 columns must be non-zero, odd weight and unique.
    function automatic bit columns_ok();
        logic [CW_BITS-1:0][7:0] col;
        col = '0;
        for (int b = 0; b < CW_BITS; b++) begin
            for (int r = 0; r < PAR_BITS; r++) begin
                if (b < PAR_BITS) begin
                    col[b][r] = H_PAR[r][b];
                end else begin
                    col[b][r] = H_DATA[r][b-PAR_BITS];
                end
            end
        end
        for (int a = 0; a < CW_BITS; a++) begin
            if (popcount8(col[a]) % 2 == 0) begin
                return 1'b0;
            end
            for (int b = a + 1; b < CW_BITS; b++) begin
                if (col[a] == col[b]) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    localparam bit P_INV_OK   = p_inv_ok();
    localparam bit COLUMNS_OK = columns_ok();

    // Full 72-bit syndrome; zero for every valid codeword. Used by the decoder.
    function automatic parity_t syndrome(input codeword_t cw);
        parity_t s;
        s = '0;
        for (int r = 0; r < PAR_BITS; r++) begin
            s[r] = (^(cw[CW_BITS-1:PAR_BITS] & H_DATA[r])) ^ (^(cw[PAR_BITS-1:0] & H_PAR[r]));
        end
        return s;
    endfunction

endpackage

// File: rtl/sec_ded_encoder_pipe_if.sv
// Stream bundle around the encoder: message input with optional fault mask,
// codeword output. Both sides use valid/ready: a word moves on a rising edge
// where valid and ready are both high; a source holds valid and payload
// stable until that edge, and ready never depends on valid of the same side.
interface sec_ded_encoder_pipe_if;
    import sec_ded_encoder_pipe_pkg::*;

    logic      in_valid;
    logic      in_ready;
    msg_t      in_msg;
    logic      inj_valid;
    codeword_t inj_mask;
    logic      out_valid;
    logic      out_ready;
    codeword_t out_codeword;
    logic      out_injected;

    // Encoder side.
    modport slave (
        input  in_valid, in_msg, inj_valid, inj_mask, out_ready,
        output in_ready, out_valid, out_codeword, out_injected
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_msg, inj_valid, inj_mask, out_ready,
        input  in_ready, out_valid, out_codeword, out_injected
    );

endinterface

// File: rtl/sec_ded_encoder_pipe_parity_core.sv
// Combinational halves of the parity computation. f: message -> data
// syndrome (H_DATA * msg). g: data syndrome -> parity (P_INV * s_d).
// Kept apart so a pipeline register can sit between them, or not.
module sec_ded_encoder_pipe_parity_core
    import sec_ded_encoder_pipe_pkg::*;
(
    input  msg_t    i_msg,
    output parity_t o_sd,
    input  parity_t i_sd,
    output parity_t o_parity
);

    // Data syndrome: each bit is the parity of the message bits its row selects.
    always_comb begin
        o_sd = '0;
        for (int r = 0; r < PAR_BITS; r++) begin
            o_sd[r] = ^(i_msg & H_DATA[r]);
        end
    end

    // Parity that cancels the data syndrome through the parity columns.
    always_comb begin
        o_parity = '0;
        for (int r = 0; r < PAR_BITS; r++) begin
            o_parity[r] = ^(i_sd & P_INV[r]);
        end
    end

endmodule

// File: rtl/sec_ded_encoder_pipe.sv
// Two-stage streaming (72,64) SEC-DED encoder. Stage 1 registers the message,
// the fault mask and the data syndrome; stage 2 is the output register holding
// {message, parity} ^ mask. Flow control collapses bubbles: a stage loads
// whenever it is empty or the stage after it is moving.
module sec_ded_encoder_pipe
    import sec_ded_encoder_pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PAR_W  = 8,
    parameter bit INJ_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sec_ded_encoder_pipe_if.slave   bus,
    output logic [15:0]             inj_cnt
);

    if (DATA_W != MSG_BITS || PAR_W != PAR_BITS) begin : g_bad_width
        $error("sec_ded_encoder_pipe supports only DATA_W=64, PAR_W=8");
    end
    if (!P_INV_OK || !COLUMNS_OK) begin : g_bad_code
        $error("sec_ded_encoder_pipe: parity-check matrix is not a valid SEC-DED code");
    end

    logic      w_s2_adv;
    logic      w_s1_adv;
    logic      w_in_xfer;
    logic      w_out_xfer;
    codeword_t w_in_mask;
    parity_t   w_sd;
    parity_t   w_parity;
    codeword_t w_s2_cw;

    logic      r_s1_v;
    msg_t      r_s1_msg;
    codeword_t r_s1_mask;
    parity_t   r_s1_sd;

    logic      r_s2_v;
    codeword_t r_s2_cw;
    logic      r_s2_inj;

    logic [15:0] r_inj_cnt;

    assign w_s2_adv   = !r_s2_v || bus.out_ready;
    assign w_s1_adv   = !r_s1_v || w_s2_adv;
    assign w_in_xfer  = bus.in_valid && w_s1_adv;
    assign w_out_xfer = r_s2_v && bus.out_ready;
    assign w_in_mask  = (INJ_EN && bus.inj_valid) ? bus.inj_mask : '0;

    sec_ded_encoder_pipe_parity_core u_core (
        .i_msg    (bus.in_msg),
        .o_sd     (w_sd),
        .i_sd     (r_s1_sd),
        .o_parity (w_parity)
    );

    assign w_s2_cw = {r_s1_msg, w_parity} ^ r_s1_mask;

    // Stage 1: capture message, mask and data syndrome only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_msg  <= '0;
            r_s1_mask <= '0;
            r_s1_sd   <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= bus.in_valid;
            if (w_in_xfer) begin
                r_s1_msg  <= bus.in_msg;
                r_s1_mask <= w_in_mask;
                r_s1_sd   <= w_sd;
            end
        end
    end

    // Stage 2: output register; holds while the sink stalls a valid word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_cw  <= '0;
            r_s2_inj <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_cw  <= w_s2_cw;
                r_s2_inj <= |r_s1_mask;
            end
        end
    end

    // Count delivered faulty words, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_cnt <= '0;
        end else if (INJ_EN && w_out_xfer && r_s2_inj && r_inj_cnt != 16'hFFFF) begin
            r_inj_cnt <= r_inj_cnt + 16'd1;
        end
    end

    assign bus.in_ready     = w_s1_adv;
    assign bus.out_valid    = r_s2_v;
    assign bus.out_codeword = r_s2_cw;
    assign bus.out_injected = r_s2_inj;
    assign inj_cnt          = r_inj_cnt;

endmodule

// File: tb/tb_sec_ded_encoder_pipe.sv
// Bench for sec_ded_encoder_pipe. Reference code: codeword bit j (j<8) has
// syndrome column 1<<j; codeword bit 8+i has the i-th byte value (ascending)
// of weight 3 or 5. A codeword is valid when the XOR of the columns of its set
// bits is zero; encoding picks the parity bits that cancel the data columns.
module tb_sec_ded_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] inj_cnt;

    sec_ded_encoder_pipe_if bus ();

    sec_ded_encoder_pipe #(.DATA_W(64), .PAR_W(8), .INJ_EN(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .inj_cnt (inj_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [72:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    logic        held_v = 1'b0;
    logic [71:0] held_cw = '0;
    logic        held_inj = 1'b0;
    logic [71:0] last_cw = '0;
    logic [7:0]  m_col [72];

    typedef struct {
        logic [63:0] msg;
        logic [71:0] exp_cw;
    } vec_t;
    vec_t vecs [68];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic build_model();
        int n;
        n = 0;
        for (int j = 0; j < 8; j++) m_col[j] = 8'h01 << j;
        for (int v = 1; v < 256; v++) begin
            if (($countones(v[7:0]) == 3 || $countones(v[7:0]) == 5) && n < 64) begin
                m_col[8+n] = v[7:0];
                n++;
            end
        end
    endtask

    function automatic logic [7:0] m_syndrome(input logic [71:0] cw);
        logic [7:0] s;
        s = '0;
        for (int b = 0; b < 72; b++) if (cw[b]) s ^= m_col[b];
        return s;
    endfunction

    // Parity bit j is the only parity bit hitting syndrome bit j.
    function automatic logic [71:0] m_encode(input logic [63:0] m);
        return {m, m_syndrome({m, 8'h00})};
    endfunction

    function automatic logic [1:0] m_decode(input logic [71:0] cw, output int addr, output logic [63:0] msg);
        logic [7:0]  s;
        logic [71:0] c;
        s = m_syndrome(cw);
        addr = -1;
        msg = cw[71:8];
        if (s == 8'h00) return 2'b00;
        for (int b = 0; b < 72; b++) begin
            if (m_col[b] == s) begin
                addr = b;
                c = cw ^ (72'h1 << b);
                msg = c[71:8];
                return 2'b01;
            end
        end
        return 2'b11;
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_msg    = '0;
        bus.inj_valid = 1'b0;
        bus.inj_mask  = '0;
        bus.out_ready = 1'b0;
    endtask

    // One clock: check stall hold, drive, then score the transfers of the coming edge.
    task automatic cycle(input logic iv, input logic [63:0] m, input logic jv, input logic [71:0] mk,
                         input logic [71:0] ecw, input logic einj, input logic ordy, output logic acc);
        logic [72:0] e;
        @(negedge clk);
        if (held_v) begin
            check("stall_hold", 80'({bus.out_valid, bus.out_injected, bus.out_codeword}), 80'({1'b1, held_inj, held_cw}));
        end
        bus.in_valid  = iv;
        bus.in_msg    = iv ? m : 'x;
        bus.inj_valid = jv;
        bus.inj_mask  = mk;
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        if (acc) exp_q.push_back({einj, ecw});
        if (bus.out_valid && ordy) begin
            last_cw = bus.out_codeword;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: actual %0h required none", bus.out_codeword);
            end else begin
                e = exp_q.pop_front();
                check("codeword", 80'(bus.out_codeword), 80'(e[71:0]));
                check("injected", 80'(bus.out_injected), 80'(e[72]));
                if (!e[72]) check("syndrome", 80'(m_syndrome(bus.out_codeword)), 80'(0));
                if (e[72] && exp_cnt != 16'hFFFF) exp_cnt++;
            end
        end
        held_v   = bus.out_valid && !ordy;
        held_cw  = bus.out_codeword;
        held_inj = bus.out_injected;
    endtask

    task automatic drain(input int budget);
        logic a;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        end
        check("drain_empty", 80'(exp_q.size()), 80'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        held_v  = 1'b0;
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Word presented now must be absent one clock later and present the clock after.
    task automatic latency_word(input logic [63:0] m, input logic [71:0] ecw);
        logic a;
        cycle(1'b1, m, 1'b0, '0, ecw, 1'b0, 1'b1, a);
        check("latency_accept", 80'(a), 80'(1));
        cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        check("latency_early", 80'(bus.out_valid), 80'(0));
        cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        check("latency_due", 80'(bus.out_valid), 80'(1));
        check("latency_cw", 80'(last_cw), 80'(ecw));
    endtask

    task automatic send_one(input logic [63:0] m, input logic jv, input logic [71:0] mk);
        logic a;
        cycle(1'b1, m, jv, mk, m_encode(m) ^ (jv ? mk : 72'h0), jv && (mk != 72'h0), 1'b1, a);
        drain(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic        a;
        logic [63:0] m;
        logic [71:0] mk;
        logic        iv, jv;
        logic [1:0]  et;
        int          addr;
        int          sent;
        logic [63:0] rec;

        idle_inputs();
        build_model();

        // Vector table: zero, walking ones, all ones, two alternating patterns.
        vecs[0] = '{64'h0, 72'h0};
        for (int i = 0; i < 64; i++) vecs[1+i] = '{64'h1 << i, m_encode(64'h1 << i)};
        vecs[65] = '{64'hFFFF_FFFF_FFFF_FFFF, m_encode(64'hFFFF_FFFF_FFFF_FFFF)};
        vecs[66] = '{64'hAAAA_AAAA_AAAA_AAAA, m_encode(64'hAAAA_AAAA_AAAA_AAAA)};
        vecs[67] = '{64'h5555_5555_5555_5555, m_encode(64'h5555_5555_5555_5555)};

        // Reset state.
        do_reset();
        #1;
        check("reset_out_valid", 80'(bus.out_valid), 80'(0));
        check("reset_out_codeword", 80'(bus.out_codeword), 80'(0));
        check("reset_out_injected", 80'(bus.out_injected), 80'(0));
        check("reset_inj_cnt", 80'(inj_cnt), 80'(0));
        check("reset_in_ready", 80'(bus.in_ready), 80'(1));

        // Zero message: all-zero codeword, latency and syndrome.
        latency_word(64'h0, 72'h0);

        // Back-to-back table at full rate.
        for (int i = 0; i < 68; i++) begin
            cycle(1'b1, vecs[i].msg, 1'b0, '0, vecs[i].exp_cw, 1'b0, 1'b1, a);
            check("table_in_ready", 80'(a), 80'(1));
        end
        drain(8);

        // Random traffic with stalls and occasional injections.
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            iv = ($urandom_range(99, 0) < 70);
            jv = ($urandom_range(15, 0) == 0);
            m  = {$urandom, $urandom};
            mk = {8'($urandom), $urandom, $urandom};
            cycle(iv, m, jv, mk, m_encode(m) ^ (jv ? mk : 72'h0), jv && (mk != 72'h0),
                  ($urandom_range(99, 0) >= 30), a);
            if (a) sent++;
        end
        check("random_sent", 80'(sent), 80'(10000));
        drain(16);
        check("random_inj_cnt", 80'(inj_cnt), 80'(exp_cnt));

        // Fault injection seen through the reference decoder.
        do_reset();
        send_one(64'hDEAD_BEEF_0123_4567, 1'b1, 72'h1);
        et = m_decode(last_cw, addr, rec);
        check("inj1_type", 80'(et), 80'(2'b01));
        check("inj1_addr", 80'(addr), 80'(0));
        check("inj1_msg", 80'(rec), 80'(64'hDEAD_BEEF_0123_4567));
        send_one(64'hDEAD_BEEF_0123_4567, 1'b1, 72'h3);
        et = m_decode(last_cw, addr, rec);
        check("inj2_type", 80'(et), 80'(2'b11));
        send_one(64'hDEAD_BEEF_0123_4567, 1'b1, 72'h0);
        check("inj0_clean", 80'(last_cw), 80'(m_encode(64'hDEAD_BEEF_0123_4567)));
        check("inj_cnt_two", 80'(inj_cnt), 80'(16'd2));

        // Saturation from a preloaded count.
        @(negedge clk);
        force dut.r_inj_cnt = 16'hFFFD;
        #1;
        release dut.r_inj_cnt;
        exp_cnt = 16'hFFFD;
        check("preload", 80'(inj_cnt), 80'(16'hFFFD));
        for (int k = 0; k < 3; k++) begin
            send_one({$urandom, $urandom}, 1'b1, 72'h1 << $urandom_range(71, 0));
        end
        check("sat_model", 80'(inj_cnt), 80'(exp_cnt));
        check("sat_value", 80'(inj_cnt), 80'(16'hFFFF));

        // Reset with both stages full and the sink stalled.
        cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 72'h10, m_encode(64'h1234_5678_9ABC_DEF0) ^ 72'h10, 1'b1, 1'b0, a);
        cycle(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, '0, m_encode(64'h0F0F_0F0F_0F0F_0F0F), 1'b0, 1'b0, a);
        @(negedge clk);
        idle_inputs();
        #1;
        check("full_out_valid", 80'(bus.out_valid), 80'(1));
        check("full_in_ready", 80'(bus.in_ready), 80'(0));
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 80'(bus.out_valid), 80'(0));
        check("midreset_inj_cnt", 80'(inj_cnt), 80'(0));
        check("midreset_codeword", 80'(bus.out_codeword), 80'(0));
        exp_q.delete();
        held_v  = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m = {$urandom, $urandom};
        latency_word(m, m_encode(m));
        repeat (3) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        check("post_reset_idle", 80'(bus.out_valid), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
